// File: rtl/seq_comparator_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package seq_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must hold NDIG-1; keep at least one bit for the single-digit case.
    function automatic int calc_cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_comparator_digit_cmp.sv
// Combinational DIGIT-bit unsigned magnitude compare; equality is neither gt nor lt.
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             gt,
    output logic             lt
);

    assign gt = (a_d > b_d);
    assign lt = (a_d < b_d);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit,
// signed/unsigned per operation, start/busy/done handshake, all outputs registered.
module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             agtb_o,
    output logic             altb_o,
    output logic             aeqb_o
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cnt_width(WIDTH, DIGIT);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_comparator: DIGIT must be >= 1 and divide WIDTH (>= 2)");
    end

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             agtb_r;
    logic             altb_r;
    logic             aeqb_r;

    logic             load_s;
    logic             step_s;
    logic             set_gt_s;
    logic             set_lt_s;
    logic             set_eq_s;
    logic             gt_s;
    logic             lt_s;
    logic [WIDTH-1:0] sign_flip_s;

    // Operands are shifted left each step, so the current digit always sits at the top.
    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a_d (a_r[WIDTH-1 -: DIGIT]),
        .b_d (b_r[WIDTH-1 -: DIGIT]),
        .gt  (gt_s),
        .lt  (lt_s)
    );

    // Biasing the sign bit turns a two's complement compare into an unsigned one.
    always_comb begin
        sign_flip_s          = '0;
        sign_flip_s[WIDTH-1] = signed_i;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        set_gt_s = 1'b0;
        set_lt_s = 1'b0;
        set_eq_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    load_s  = 1'b1;
                    state_s = ST_CMP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (gt_s) begin
                    set_gt_s = 1'b1;
                    state_s  = ST_DONE;
                end else if (lt_s) begin
                    set_lt_s = 1'b1;
                    state_s  = ST_DONE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    set_eq_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    step_s   = 1'b1;
                    state_s  = ST_CMP;
                end
            end
            ST_DONE: begin
                // The edge closing the done cycle may accept the next operation directly.
                if (start_i) begin
                    load_s  = 1'b1;
                    state_s = ST_CMP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shift registers, digit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            agtb_r <= 1'b0;
            altb_r <= 1'b0;
            aeqb_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            if (load_s) begin
                a_r    <= a_i ^ sign_flip_s;
                b_r    <= b_i ^ sign_flip_s;
                cnt_r  <= CW'(NDIG - 1);
                agtb_r <= 1'b0;
                altb_r <= 1'b0;
                aeqb_r <= 1'b0;
            end else if (step_s) begin
                a_r   <= a_r << DIGIT;
                b_r   <= b_r << DIGIT;
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
            if (set_gt_s) agtb_r <= 1'b1;
            if (set_lt_s) altb_r <= 1'b1;
            if (set_eq_s) aeqb_r <= 1'b1;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign agtb_o = agtb_r;
    assign altb_o = altb_r;
    assign aeqb_o = aeqb_r;

endmodule
